// File: rtl/regfile_pkg.sv
// Shared widths and types for the rename-aware architectural register file.
// Register count, register-id width and ROB geometry are defined here only.
package regfile_pkg;

   localparam int unsigned REG_NUM       = 32;
   localparam int unsigned REG_ID_BIT    = 5;
   localparam int unsigned ROB_WIDTH     = 16;
   localparam int unsigned ROB_WIDTH_BIT = 4;
   localparam int unsigned DATA_BIT      = 32;

   typedef logic [REG_ID_BIT-1:0]    reg_id_t;
   typedef logic [ROB_WIDTH_BIT-1:0] rob_tag_t;
   typedef logic [DATA_BIT-1:0]      word_t;

endpackage

// File: rtl/regfile_if.sv
// Decoder/ROB-facing bundle of the register file: rename, commit, flush and
// the two source read ports.
interface regfile_if
   import regfile_pkg::*;
   ();

   logic     rename_en;
   reg_id_t  rename_rd;
   rob_tag_t rename_tag;

   logic     commit_en;
   reg_id_t  commit_rd;
   rob_tag_t commit_tag;
   word_t    commit_value;

   logic     clear_all;

   reg_id_t  rs1_id;
   reg_id_t  rs2_id;
   logic     rs1_busy;
   logic     rs2_busy;
   rob_tag_t rs1_tag;
   rob_tag_t rs2_tag;
   word_t    rs1_value;
   word_t    rs2_value;

   modport master (
      output rename_en, rename_rd, rename_tag,
      output commit_en, commit_rd, commit_tag, commit_value,
      output clear_all,
      output rs1_id, rs2_id,
      input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_value, rs2_value
   );

   modport slave (
      input  rename_en, rename_rd, rename_tag,
      input  commit_en, commit_rd, commit_tag, commit_value,
      input  clear_all,
      input  rs1_id, rs2_id,
      output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_value, rs2_value
   );

endinterface

// File: rtl/regfile.sv
// Architectural register file with per-register busy/tag rename state and a
// same-cycle commit bypass on both source read ports.
module regfile
   import regfile_pkg::*;
(
   input  logic      clk_in,
   input  logic      rst_in,
   input  logic      rdy_in,
   regfile_if.slave  bus
);

   word_t              value_q [REG_NUM];
   rob_tag_t           tag_q   [REG_NUM];
   logic [REG_NUM-1:0] busy_q;

   logic commit_wr;
   logic rename_wr;
   logic commit_retires;

   assign commit_wr = rdy_in && bus.commit_en && (bus.commit_rd != '0);
   assign rename_wr = rdy_in && bus.rename_en && (bus.rename_rd != '0) && !bus.clear_all;

   // A commit retires the in-flight producer only if it is still the latest
   // one and is not being superseded by a rename in this very cycle.
   assign commit_retires = commit_wr && busy_q[bus.commit_rd] &&
                           (tag_q[bus.commit_rd] == bus.commit_tag) &&
                           !(bus.rename_en && (bus.rename_rd == bus.commit_rd));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
      end else begin
         if (commit_wr) begin
            value_q[bus.commit_rd] <= bus.commit_value;
         end
         if (rdy_in && bus.clear_all) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
               tag_q[i] <= '0;
            end
         end else begin
            if (commit_retires) begin
               busy_q[bus.commit_rd] <= 1'b0;
               tag_q[bus.commit_rd]  <= '0;
            end
            if (rename_wr) begin
               busy_q[bus.rename_rd] <= 1'b1;
               tag_q[bus.rename_rd]  <= bus.rename_tag;
            end
         end
      end
   end

   // Read port 1. Bypass is gated by rdy_in so a paused pipeline sees held state.
   always_comb begin
      bus.rs1_busy  = 1'b0;
      bus.rs1_tag   = '0;
      bus.rs1_value = '0;
      if (bus.rs1_id != '0) begin
         if (rdy_in && bus.commit_en && (bus.commit_rd == bus.rs1_id) &&
             busy_q[bus.rs1_id] && (tag_q[bus.rs1_id] == bus.commit_tag) &&
             !(bus.rename_en && (bus.rename_rd == bus.rs1_id))) begin
            bus.rs1_value = bus.commit_value;
         end else if (busy_q[bus.rs1_id]) begin
            bus.rs1_busy = 1'b1;
            bus.rs1_tag  = tag_q[bus.rs1_id];
         end else begin
            bus.rs1_value = value_q[bus.rs1_id];
         end
      end
   end

   // Read port 2, same structure as port 1.
   always_comb begin
      bus.rs2_busy  = 1'b0;
      bus.rs2_tag   = '0;
      bus.rs2_value = '0;
      if (bus.rs2_id != '0) begin
         if (rdy_in && bus.commit_en && (bus.commit_rd == bus.rs2_id) &&
             busy_q[bus.rs2_id] && (tag_q[bus.rs2_id] == bus.commit_tag) &&
             !(bus.rename_en && (bus.rename_rd == bus.rs2_id))) begin
            bus.rs2_value = bus.commit_value;
         end else if (busy_q[bus.rs2_id]) begin
            bus.rs2_busy = 1'b1;
            bus.rs2_tag  = tag_q[bus.rs2_id];
         end else begin
            bus.rs2_value = value_q[bus.rs2_id];
         end
      end
   end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  asynchronous, active-high reset.
REQ-004 rdy_in  input  1  pause when low; all state holds.
REQ-005 rename_en  input  1  decoder issues an instruction that writes rename_rd.
REQ-006 rename_rd  input  `REG_ID_BIT  architectural destination register.
REQ-007 rename_tag  input  `ROB_WIDTH_BIT  ROB entry allocated to that instruction.
REQ-008 commit_en  input  1  ROB commit write (ROB rf_write_en).
REQ-009 commit_rd  input  `REG_ID_BIT  committed destination register (ROB reg_id).
REQ-010 commit_tag  input  `ROB_WIDTH_BIT  committing ROB entry (ROB rob_id).
REQ-011 commit_value  input  32  committed result (ROB value_out).
REQ-012 clear_all  input  1  mispredict flush from ROB.
REQ-013 rs1_id, rs2_id  input  `REG_ID_BIT each  decoder source register indices.
REQ-014 rs1_busy, rs2_busy  output  1 each  source still awaits an in-flight producer.
REQ-015 rs1_tag, rs2_tag  output  `ROB_WIDTH_BIT each  producer ROB entry; 0 when not busy.
REQ-016 rs1_value, rs2_value  output  32 each  architectural value; 0 when busy.

Function
REQ-017 State: 32 x 32-bit registers, 32 busy bits, 32 tags of `ROB_WIDTH_BIT.
REQ-018 Register x0 SHALL always read value 0, busy 0, tag 0; writes and renames to x0 ignored.
REQ-019 Read ports SHALL be combinational (zero latency) from current state plus commit bypass.
REQ-020 Bypass: when commit_en, commit_rd == rsN_id != 0, and commit_tag equals that register's tag with busy set, rsN SHALL report busy 0, value commit_value, tag 0 in the same cycle.
REQ-021 Bypass SHALL NOT apply when rename_en targets the same register in the same cycle (read returns pre-rename state; decoder handles self-dependency).
REQ-022 Commit (rdy_in high, commit_en, commit_rd != 0): value SHALL be written next edge regardless of tag.
REQ-023 Commit SHALL clear busy only if stored tag == commit_tag and no same-cycle rename to that register.
REQ-024 Rename (rdy_in high, rename_en, rename_rd != 0, clear_all low): busy set, tag := rename_tag next edge.
REQ-025 Simultaneous rename and commit same register: value := commit_value, busy stays 1, tag := rename_tag.
REQ-026 clear_all high: all busy bits and tags SHALL clear next edge; same-cycle commit value still written; same-cycle rename dropped.
REQ-027 rdy_in low: no state change; read ports still reflect held state.
REQ-028 Tag wrap-around: tags compared by equality only; reuse of a tag after ROB wrap requires no special handling.

Reset
REQ-029 rst_in high SHALL immediately clear all registers, busy bits and tags to 0, independent of clk_in.
REQ-030 During and after reset all read outputs SHALL be busy 0, tag 0, value 0 for every index.
REQ-031 Reset asserted mid-operation SHALL discard pending rename/commit of that cycle.

Structure
REQ-032 `REG_ID_BIT, `ROB_WIDTH_BIT, `ROB_WIDTH and register count SHALL come from shared const.v; no local redefinition.
REQ-033 Single flat module; no sub-module; read-port logic duplicated per port.

Verification
REQ-034 Reset, then read x5 -> busy 0, value 0, tag 0.
REQ-035 Rename x5 tag 3; next cycle read x5 -> busy 1, tag 3, value 0; commit x5 tag 3 value 0x1234 -> same-cycle read busy 0 value 0x1234; next cycle stored value 0x1234, busy 0.
REQ-036 Rename x7 tag 2, then rename x7 tag 6; commit x7 tag 2 value 0xAA -> value 0xAA stored, busy stays 1, tag 6.
REQ-037 Same-cycle commit x9 tag 1 value 0x55 and rename x9 tag 4 -> next cycle busy 1, tag 4, stored value 0x55.
REQ-038 Rename x1..x3 tags 1..3, assert clear_all with rename x4 tag 5 -> next cycle all busy 0, x4 not busy.
REQ-039 Commit x0 value 0xFFFF and rename x0 -> x0 reads value 0, busy 0; with rdy_in low, rename x8 -> x8 unchanged.
